// File: rtl/quad_decoder_pkg.sv
// Shared types and helpers for the quadrature decoder: phase-state encoding,
// error-counter width and the transition classifier.
package quad_decoder_pkg;

    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S10 = 2'b10,
        S11 = 2'b11,
        S01 = 2'b01
    } phase_t;

    typedef enum logic [1:0] {
        DEC_NONE    = 2'd0,
        DEC_UP      = 2'd1,
        DEC_DOWN    = 2'd2,
        DEC_ILLEGAL = 2'd3
    } dec_t;

    // Successor of a state when phase A leads phase B.
    function automatic phase_t phase_next_up(input phase_t s);
        phase_t r;
        case (s)
            S00:     r = S10;
            S10:     r = S11;
            S11:     r = S01;
            default: r = S00;
        endcase
        return r;
    endfunction

    function automatic dec_t qdec_decode(input phase_t prev, input phase_t cur);
        dec_t r;
        if (cur == prev) begin
            r = DEC_NONE;
        end else if (cur == phase_next_up(prev)) begin
            r = DEC_UP;
        end else if (prev == phase_next_up(cur)) begin
            r = DEC_DOWN;
        end else begin
            r = DEC_ILLEGAL;
        end
        return r;
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Signal bundle between a quadrature source/consumer and quad_decoder.
// QUAD_DECODER_INDEX_EN adds the index input qi and the sticky idx_seen flag.
interface quad_decoder_if #(
    parameter int N = 16
);
    import quad_decoder_pkg::*;

    logic                 qa;
    logic                 qb;
    logic                 enable;
    logic                 clr;
    logic [N-1:0]         count;
    logic                 step;
    logic                 dir;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;
`ifdef QUAD_DECODER_INDEX_EN
    logic                 qi;
    logic                 idx_seen;

    modport master (
        output qa, qb, enable, clr, qi,
        input  count, step, dir, err, err_cnt, idx_seen
    );

    modport slave (
        input  qa, qb, enable, clr, qi,
        output count, step, dir, err, err_cnt, idx_seen
    );
`else
    modport master (
        output qa, qb, enable, clr,
        input  count, step, dir, err, err_cnt
    );

    modport slave (
        input  qa, qb, enable, clr,
        output count, step, dir, err, err_cnt
    );
`endif

endinterface

// File: rtl/qdec_filter.sv
// Two-flop synchronizer followed by a persistence filter: the output follows
// the synchronized input only after FILT consecutive samples of the new level.
module qdec_filter #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       out_q;
    logic       out_d;
    logic [3:0] run_q;
    logic [3:0] run_d;

    // run_q counts how many samples in a row have disagreed with the output.
    always_comb begin
        out_d = out_q;
        run_d = '0;
        if (sync2_q != out_q) begin
            if (run_q == 4'(FILT - 1)) begin
                out_d = sync2_q;
            end else begin
                run_d = run_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            out_q   <= 1'b0;
            run_q   <= '0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            out_q   <= out_d;
            run_q   <= run_d;
        end
    end

    assign q_o = out_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phases drive a wrapping position counter.
// Optional index support is compiled in with QUAD_DECODER_INDEX_EN.
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int N    = 16,
    parameter int FILT = 3
) (
    input  logic          clk,
    input  logic          rst,
    quad_decoder_if.slave bus
);

    // Filter outputs are trustworthy once the sync chain and one full filter window have passed.
    localparam logic [4:0] WARM = 5'(FILT + 2);

    logic                 a_f;
    logic                 b_f;
    phase_t               filt_ab;
    dec_t                 dec;

    logic [4:0]           warm_q, warm_d;
    logic                 primed_q, primed_d;
    phase_t               state_q, state_d;
    logic [N-1:0]         count_q, count_d;
    logic                 step_q, step_d;
    logic                 dir_q, dir_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    qdec_filter #(.FILT(FILT)) u_filt_a (.clk(clk), .rst(rst), .d_i(bus.qa), .q_o(a_f));
    qdec_filter #(.FILT(FILT)) u_filt_b (.clk(clk), .rst(rst), .d_i(bus.qb), .q_o(b_f));

`ifdef QUAD_DECODER_INDEX_EN
    logic i_f;
    logic qi_q, qi_d;
    logic idx_q, idx_d;

    qdec_filter #(.FILT(FILT)) u_filt_i (.clk(clk), .rst(rst), .d_i(bus.qi), .q_o(i_f));
`endif

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        filt_ab   = phase_t'({a_f, b_f});
        dec       = qdec_decode(state_q, filt_ab);
        warm_d    = (warm_q == WARM) ? warm_q : warm_q + 5'd1;
        primed_d  = primed_q;
        state_d   = state_q;
        count_d   = count_q;
        step_d    = 1'b0;
        dir_d     = dir_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
`ifdef QUAD_DECODER_INDEX_EN
        qi_d      = qi_q;
        idx_d     = idx_q;
`endif
        if (!primed_q) begin
            if (warm_q == WARM) begin
                primed_d = 1'b1;
                state_d  = filt_ab;
`ifdef QUAD_DECODER_INDEX_EN
                qi_d     = i_f;
`endif
            end
        end else begin
            state_d = filt_ab;
            if (bus.enable) begin
                case (dec)
                    DEC_UP: begin
                        count_d = count_q + N'(1);
                        step_d  = 1'b1;
                        dir_d   = 1'b1;
                    end
                    DEC_DOWN: begin
                        count_d = count_q - N'(1);
                        step_d  = 1'b1;
                        dir_d   = 1'b0;
                    end
                    DEC_ILLEGAL: begin
                        err_d     = 1'b1;
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                    default: ;
                endcase
            end
`ifdef QUAD_DECODER_INDEX_EN
            qi_d = i_f;
            if (bus.enable && i_f && !qi_q && (filt_ab == S11)) begin
                count_d = '0;
                step_d  = 1'b0;
                dir_d   = dir_q;
                idx_d   = 1'b1;
            end
`endif
        end
        // Clear wins over index and step; an illegal-transition pulse still shows.
        if (bus.clr) begin
            count_d   = '0;
            err_cnt_d = '0;
            step_d    = 1'b0;
            dir_d     = dir_q;
`ifdef QUAD_DECODER_INDEX_EN
            idx_d     = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_q    <= '0;
            primed_q  <= 1'b0;
            state_q   <= S00;
            count_q   <= '0;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
`ifdef QUAD_DECODER_INDEX_EN
            qi_q      <= 1'b0;
            idx_q     <= 1'b0;
`endif
        end else begin
            warm_q    <= warm_d;
            primed_q  <= primed_d;
            state_q   <= state_d;
            count_q   <= count_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
`ifdef QUAD_DECODER_INDEX_EN
            qi_q      <= qi_d;
            idx_q     <= idx_d;
`endif
        end
    end

    assign bus.count   = count_q;
    assign bus.step    = step_q;
    assign bus.dir     = dir_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
`ifdef QUAD_DECODER_INDEX_EN
    assign bus.idx_seen = idx_q;
`endif

endmodule
